// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the 32x32 register file: buffers requests in a
// small FIFO, drains one per cycle onto the registered write port, forwards reads.
module regfile_wb_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_data,
    input  logic                      rf_hold,
    output logic                      rf_write,
    output logic [ADDR_W-1:0]         rf_wraddr,
    output logic [DATA_W-1:0]         rf_wrdata,
    input  logic [ADDR_W-1:0]         rd_addr1,
    input  logic [ADDR_W-1:0]         rd_addr2,
    input  logic [DATA_W-1:0]         rd_data1_in,
    input  logic [DATA_W-1:0]         rd_data2_in,
    output logic [DATA_W-1:0]         rd_data1,
    output logic [DATA_W-1:0]         rd_data2,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] data_q_r [DEPTH];
    logic [ADDR_W-1:0] addr_q_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_s;
    logic              pop_s;

    assign req_ready = (count_r != CNT_W'(DEPTH));
    assign count     = count_r;

    // Handshake decode: push only when not full, pop whenever data waits and the file is free
    always_comb begin
        push_s = req_valid && req_ready;
        pop_s  = (count_r != {CNT_W{1'b0}}) && !rf_hold;
    end

    // Queue storage: accepted requests land at the tail slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q_r[i] <= {DATA_W{1'b0}};
                addr_q_r[i] <= {ADDR_W{1'b0}};
            end
        end else if (push_s) begin
            data_q_r[wr_ptr_r] <= req_data;
            addr_q_r[wr_ptr_r] <= req_addr;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered write port: address/data hold their last value while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write  <= 1'b0;
            rf_wraddr <= {ADDR_W{1'b0}};
            rf_wrdata <= {DATA_W{1'b0}};
        end else if (pop_s) begin
            rf_write  <= 1'b1;
            rf_wraddr <= addr_q_r[rd_ptr_r];
            rf_wrdata <= data_q_r[rd_ptr_r];
        end else begin
            rf_write  <= 1'b0;
        end
    end

    // Walk oldest to newest so the newest matching queue entry wins over the output stage and the file
    function automatic logic [DATA_W-1:0] forward_fn(input logic [ADDR_W-1:0] ra,
                                                     input logic [DATA_W-1:0] raw);
        logic [DATA_W-1:0] res;
        logic [PTR_W-1:0]  idx;
        res = (rf_write && (rf_wraddr == ra)) ? rf_wrdata : raw;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_r + PTR_W'(i);
            res = ((CNT_W'(i) < count_r) && (addr_q_r[idx] == ra)) ? data_q_r[idx] : res;
        end
        return res;
    endfunction

    // Forwarded read data for both ports
    always_comb begin
        rd_data1 = forward_fn(rd_addr1, rd_data1_in);
        rd_data2 = forward_fn(rd_addr2, rd_data2_in);
    end

endmodule
